// File: rtl/cpu_pkg.sv
// Shared CPU types for the execute/writeback slice: flag bit positions, the
// EX/WB buffer occupancy states and the buffered-entry record.
package cpu_pkg;

  localparam int FLAG_Z = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 0;

  localparam int EXWB_DW = 32;
  localparam int EXWB_AW = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } exwb_state_t;

  typedef struct packed {
    logic [EXWB_DW-1:0] f;
    logic [3:0]         zvnc;
    logic [EXWB_AW-1:0] rd;
    logic               rwe;
    logic               sf;
  } exwb_entry_t;

endpackage

// File: rtl/ex_wb_entry_buf.sv
// Two-entry head/skid buffer with occupancy FSM. in_ready and out_valid are
// both derived from registers, so no input reaches an output combinationally.
module ex_wb_entry_buf
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  exwb_entry_t in_entry,
  input  logic        out_ready,
  output logic        out_valid,
  output exwb_entry_t head,
  output exwb_entry_t skid,
  output exwb_state_t state
);

  exwb_state_t state_q, state_d;
  exwb_entry_t head_q, head_d;
  exwb_entry_t skid_q, skid_d;
  logic        ready_q;
  logic        accept;
  logic        commit;

  assign accept = in_valid & ready_q;
  assign commit = (state_q != EMPTY) & out_ready;

  always_comb begin
    // NOTE: every target gets a default before the case so no path leaves it unassigned (no latch).
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          head_d  = in_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && commit) begin
          head_d = in_entry;
        end else if (accept) begin
          skid_d  = in_entry;
          state_d = TWO;
        end else if (commit) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (commit) begin
          head_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush empties the buffer; any data loaded above is unreachable once EMPTY.
    if (flush) state_d = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: storage is reset as well as state because wb_* and fwd_* must read zero out of reset.
      state_q <= EMPTY;
      ready_q <= 1'b0;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q <= state_d;
      ready_q <= (state_d != TWO);
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = (state_q != EMPTY);
  assign head      = head_q;
  assign skid      = skid_q;
  assign state     = state_q;

endmodule

// File: rtl/ex_wb_stage.sv
// Execute-to-writeback stage: skid-buffered ALU results, ordered register-file
// writeback, ZVNC status register. Operand bypass enabled by EXWB_FWD_EN.
module ex_wb_stage
  import cpu_pkg::*;
#(
  parameter int DW      = EXWB_DW,
  parameter int AW      = EXWB_AW,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_f,
  input  logic [3:0]    in_zvnc,
  input  logic [AW-1:0] in_rd,
  input  logic          in_rwe,
  input  logic          in_sf,
  output logic          wb_valid,
  input  logic          wb_ready,
  output logic [DW-1:0] wb_data,
  output logic [AW-1:0] wb_rd,
  output logic          wb_we,
  output logic [3:0]    status_zvnc,
  output logic          fwd_valid,
  output logic [AW-1:0] fwd_rd,
  output logic [DW-1:0] fwd_data
);

  exwb_entry_t in_entry;
  exwb_entry_t head;
  exwb_entry_t skid;
  exwb_state_t state;
  logic        commit;

  assign in_entry = '{f: in_f, zvnc: in_zvnc, rd: in_rd, rwe: in_rwe, sf: in_sf};

  ex_wb_entry_buf u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_entry  (in_entry),
    .out_ready (wb_ready),
    .out_valid (wb_valid),
    .head      (head),
    .skid      (skid),
    .state     (state)
  );

  assign commit = wb_valid & wb_ready;

  // A commit coinciding with flush still retires the head, so it still updates flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      status_zvnc <= 4'b0000;
    end else if (commit && head.sf) begin
      status_zvnc <= head.zvnc;
    end
  end

  assign wb_data = head.f;
  assign wb_rd   = head.rd;
  assign wb_we   = head.rwe & ~(ZERO_R0 & (head.rd == '0));

`ifdef EXWB_FWD_EN
  exwb_entry_t youngest;
  logic        youngest_live;

  // Youngest entry is the skid when two are buffered, otherwise the head.
  assign youngest      = (state == TWO) ? skid : head;
  assign youngest_live = (state != EMPTY) && youngest.rwe;
  assign fwd_valid     = youngest_live;
  assign fwd_rd        = youngest_live ? youngest.rd : '0;
  assign fwd_data      = youngest_live ? youngest.f  : '0;
`else
  logic unused_skid;

  assign unused_skid = ^{skid, state};
  assign fwd_valid   = 1'b0;
  assign fwd_rd      = '0;
  assign fwd_data    = '0;
`endif

endmodule

// File: tb/tb_ex_wb_stage.sv
// Bench for ex_wb_stage: directed vector table, bypass sequence, then random
// traffic against a queue-based reference model.
module tb_ex_wb_stage;

  localparam int DW = 32;
  localparam int AW = 5;
`ifdef EXWB_FWD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, flush, in_valid, in_ready;
  logic [DW-1:0] in_f;
  logic [3:0]    in_zvnc;
  logic [AW-1:0] in_rd;
  logic          in_rwe, in_sf;
  logic          wb_valid, wb_ready;
  logic [DW-1:0] wb_data;
  logic [AW-1:0] wb_rd;
  logic          wb_we;
  logic [3:0]    status_zvnc;
  logic          fwd_valid;
  logic [AW-1:0] fwd_rd;
  logic [DW-1:0] fwd_data;

  always #5 clk = ~clk;

  ex_wb_stage #(.DW(DW), .AW(AW), .ZERO_R0(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_f(in_f), .in_zvnc(in_zvnc), .in_rd(in_rd), .in_rwe(in_rwe), .in_sf(in_sf),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_we(wb_we),
    .status_zvnc(status_zvnc),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a queue of buffered entries plus flags and ready.
  typedef struct {
    logic [DW-1:0] f;
    logic [3:0]    z;
    logic [AW-1:0] rd;
    logic          rwe;
    logic          sf;
  } ent_t;

  ent_t       mq[$];
  logic [3:0] mstat = 4'b0000;
  logic       mrdy  = 1'b0;

  task automatic model_edge();
    bit   do_commit;
    bit   do_accept;
    ent_t e;
    if (!rst_n) begin
      mq.delete();
      mstat = 4'b0000;
      mrdy  = 1'b0;
    end else begin
      do_commit = (mq.size() > 0) && wb_ready;
      do_accept = in_valid && mrdy;
      if (do_commit) begin
        if (mq[0].sf) mstat = mq[0].z;
        void'(mq.pop_front());
      end
      if (flush) begin
        mq.delete();
      end else if (do_accept) begin
        e = '{f: in_f, z: in_zvnc, rd: in_rd, rwe: in_rwe, sf: in_sf};
        mq.push_back(e);
      end
      mrdy = (mq.size() < 2);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic r, input logic fl, input logic iv, input logic [DW-1:0] f,
                       input logic [3:0] z, input logic [AW-1:0] rd, input logic rwe,
                       input logic sf, input logic wr);
    rst_n = r; flush = fl; in_valid = iv; in_f = f; in_zvnc = z;
    in_rd = rd; in_rwe = rwe; in_sf = sf; wb_ready = wr;
  endtask

  typedef struct {
    logic          r, fl, iv;
    logic [DW-1:0] f;
    logic [3:0]    z;
    logic [AW-1:0] rd;
    logic          rwe, sf, wr;
    logic          ev, er, cd;
    logic [DW-1:0] ed;
    logic [AW-1:0] erd;
    logic          ewe;
    logic [3:0]    es;
  } vec_t;

  function automatic vec_t mk(logic r, logic fl, logic iv, logic [DW-1:0] f, logic [3:0] z,
                              logic [AW-1:0] rd, logic rwe, logic sf, logic wr,
                              logic ev, logic er, logic cd, logic [DW-1:0] ed,
                              logic [AW-1:0] erd, logic ewe, logic [3:0] es);
    vec_t v;
    v = '{r: r, fl: fl, iv: iv, f: f, z: z, rd: rd, rwe: rwe, sf: sf, wr: wr,
          ev: ev, er: er, cd: cd, ed: ed, erd: erd, ewe: ewe, es: es};
    return v;
  endfunction

  vec_t vecs[$];

  task automatic check_fwd(input string name, input logic ev, input logic [AW-1:0] erd,
                           input logic [DW-1:0] ed);
    check({name, "_fwd_valid"}, fwd_valid, FWD_ON & ev);
    check({name, "_fwd_rd"}, fwd_rd, (FWD_ON & ev) ? erd : '0);
    check({name, "_fwd_data"}, fwd_data, (FWD_ON & ev) ? ed : '0);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset, single op, back-pressure, flags, R0, flush, reset mid-transfer.
    repeat (3) vecs.push_back(mk(0,0,0,0,0,0,0,0,1, 0,0,1,0,0,0,4'b0000));
    vecs.push_back(mk(1,0,0,0,0,0,0,0,1,           0,1,0,0,0,0,4'b0000));
    vecs.push_back(mk(1,0,1,5,0,3,1,1,1,           1,1,1,5,3,1,4'b0000));
    vecs.push_back(mk(1,0,0,0,0,0,0,0,1,           0,1,0,0,0,0,4'b0000));
    vecs.push_back(mk(1,0,1,1,0,1,1,0,0,           1,1,1,1,1,1,4'b0000));
    vecs.push_back(mk(1,0,1,2,0,2,1,0,0,           1,0,1,1,1,1,4'b0000));
    vecs.push_back(mk(1,0,1,9,0,9,1,0,0,           1,0,1,1,1,1,4'b0000));
    vecs.push_back(mk(1,0,0,0,0,0,0,0,1,           1,1,1,2,2,1,4'b0000));
    vecs.push_back(mk(1,0,0,0,0,0,0,0,1,           0,1,0,0,0,0,4'b0000));
    vecs.push_back(mk(1,0,1,0,4'b1000,5,1,1,1,     1,1,1,0,5,1,4'b0000));
    vecs.push_back(mk(1,0,1,7,4'b0010,6,1,0,1,     1,1,1,7,6,1,4'b1000));
    vecs.push_back(mk(1,0,0,0,0,0,0,0,1,           0,1,0,0,0,0,4'b1000));
    vecs.push_back(mk(1,0,1,'h11,0,0,1,0,0,        1,1,1,'h11,0,0,4'b1000));
    vecs.push_back(mk(1,1,1,'h22,0,8,1,0,0,        0,1,0,0,0,0,4'b1000));
    vecs.push_back(mk(1,0,0,0,0,0,0,0,1,           0,1,0,0,0,0,4'b1000));
    vecs.push_back(mk(1,0,1,'h33,4'b0101,9,1,1,0,  1,1,1,'h33,9,1,4'b1000));
    vecs.push_back(mk(1,1,1,'h44,0,10,1,1,1,       0,1,0,0,0,0,4'b0101));
    vecs.push_back(mk(1,0,0,0,0,0,0,0,1,           0,1,0,0,0,0,4'b0101));
    vecs.push_back(mk(1,0,1,'h55,4'b1111,1,1,1,0,  1,1,1,'h55,1,1,4'b0101));
    vecs.push_back(mk(0,0,1,'h66,0,2,1,1,1,        0,0,1,0,0,0,4'b0000));
    vecs.push_back(mk(1,0,0,0,0,0,0,0,1,           0,1,0,0,0,0,4'b0000));

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].fl, vecs[i].iv, vecs[i].f, vecs[i].z, vecs[i].rd,
            vecs[i].rwe, vecs[i].sf, vecs[i].wr);
      tick();
      check($sformatf("v%0d_wb_valid", i), wb_valid, vecs[i].ev);
      check($sformatf("v%0d_in_ready", i), in_ready, vecs[i].er);
      check($sformatf("v%0d_status", i), status_zvnc, vecs[i].es);
      if (vecs[i].cd) begin
        check($sformatf("v%0d_wb_data", i), wb_data, vecs[i].ed);
        check($sformatf("v%0d_wb_rd", i), wb_rd, vecs[i].erd);
        check($sformatf("v%0d_wb_we", i), wb_we, vecs[i].ewe);
      end
    end

    // Bypass: youngest buffered entry with rwe=1.
    drive(1, 0, 1, 'hA4, 0, 4, 1, 0, 0); tick();
    check_fwd("f_one", 1, 4, 'hA4);
    drive(1, 0, 1, 'hA7, 0, 7, 1, 0, 0); tick();
    check("f_two_ready", in_ready, 1'b0);
    check("f_two_wb_rd", wb_rd, 5'd4);
    check_fwd("f_two", 1, 7, 'hA7);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    check_fwd("f_pop", 1, 7, 'hA7);
    drive(1, 0, 1, 'hA8, 0, 8, 0, 0, 0); tick();
    check_fwd("f_norwe_skid", 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    check_fwd("f_norwe_head", 0, 0, 0);
    tick();
    check("f_empty_valid", wb_valid, 1'b0);
    check_fwd("f_empty", 0, 0, 0);

    // Random traffic against the reference model.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 63) != 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 3) != 0, $urandom, 4'($urandom),
            $urandom_range(0, 1) ? AW'($urandom_range(0, 2)) : AW'($urandom),
            $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 2) != 0);
      tick();
      check("rnd_wb_valid", wb_valid, mq.size() > 0);
      check("rnd_in_ready", in_ready, mrdy);
      check("rnd_status", status_zvnc, mstat);
      if (mq.size() > 0) begin
        check("rnd_wb_data", wb_data, mq[0].f);
        check("rnd_wb_rd", wb_rd, mq[0].rd);
        check("rnd_wb_we", wb_we, mq[0].rwe && (mq[0].rd != 0));
        check_fwd("rnd", mq[mq.size()-1].rwe, mq[mq.size()-1].rd, mq[mq.size()-1].f);
      end else begin
        check_fwd("rnd_empty", 0, 0, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
